// File: rtl/gelato_warp_alu_dispatch.sv
// Warp-to-lane ALU dispatcher.
// Accepts a whole-warp task and slices it into LANE_NUM-wide batches for the
// scalar ALU lanes. Each batch gets one issue pulse. Lane results are gathered
// as they arrive, and the warp result is presented once every batch is back.
module gelato_warp_alu_dispatch #(
    parameter int THREAD_NUM = 32,
    parameter int LANE_NUM   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           task_valid,
    input  logic [OP_WIDTH-1:0]            task_op,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs1,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs2,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs3,
    output logic                           task_done,
    output logic [THREAD_NUM*DATA_WIDTH-1:0] task_rd,
    output logic                           alu_valid,
    output logic [OP_WIDTH-1:0]            alu_op,
    output logic [LANE_NUM*DATA_WIDTH-1:0] alu_rs1,
    output logic [LANE_NUM*DATA_WIDTH-1:0] alu_rs2,
    output logic [LANE_NUM*DATA_WIDTH-1:0] alu_rs3,
    input  logic [LANE_NUM-1:0]            alu_done,
    input  logic [LANE_NUM*DATA_WIDTH-1:0] alu_rd
);

    localparam int BATCHES = THREAD_NUM / LANE_NUM;
    localparam int BATCH_W = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam int WARP_W  = THREAD_NUM * DATA_WIDTH;
    localparam int LANE_W  = LANE_NUM * DATA_WIDTH;
    localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(BATCHES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state;
    logic [BATCH_W-1:0]  batch;
    logic [LANE_NUM-1:0] mask;
    logic [OP_WIDTH-1:0] op_q;
    logic [WARP_W-1:0]   rs1_q;
    logic [WARP_W-1:0]   rs2_q;
    logic [WARP_W-1:0]   rs3_q;

    logic [LANE_NUM-1:0] fresh;
    logic                batch_complete;
    logic [31:0]         batch_base;

    // Only the first completion per lane counts; repeats are masked off.
    assign fresh          = alu_done & ~mask;
    assign batch_complete = &(mask | alu_done);
    assign batch_base     = LANE_W * batch;

    // Lane-facing outputs come straight from the latched operands. They stay
    // stable until the batch counter moves, and they read zero after reset.
    assign alu_valid = (state == ISSUE);
    assign task_done = (state == DONE);
    assign alu_op    = op_q;
    assign alu_rs1   = rs1_q[batch_base +: LANE_W];
    assign alu_rs2   = rs2_q[batch_base +: LANE_W];
    assign alu_rs3   = rs3_q[batch_base +: LANE_W];

    // Dispatch FSM: accept the warp, issue each batch, collect results, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide operand and result registers are reset on purpose,
            // because a reset must leave every lane-facing and warp-facing bus at
            // zero and not at a stale value.
            state   <= IDLE;
            batch   <= '0;
            mask    <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            task_rd <= '0;
        end else begin
            // NOTE: non-blocking assignments let the mask clear on batch
            // completion override the mask accumulate below it in the same cycle.
            case (state)
                IDLE: begin
                    if (task_valid) begin
                        op_q  <= task_op;
                        rs1_q <= task_rs1;
                        rs2_q <= task_rs2;
                        rs3_q <= task_rs3;
                        batch <= '0;
                        mask  <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    for (int l = 0; l < LANE_NUM; l++) begin
                        if (fresh[l]) begin
                            task_rd[batch_base + l*DATA_WIDTH +: DATA_WIDTH] <=
                                alu_rd[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    mask <= mask | alu_done;
                    if (batch_complete) begin
                        mask <= '0;
                        if (batch == BATCH_LAST) begin
                            state <= DONE;
                        end else begin
                            batch <= batch + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (!task_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gelato_warp_alu_dispatch.sv
// Directed bench for gelato_warp_alu_dispatch.
// It checks an 8-lane instance (4 batches) and a 32-lane instance (1 batch).
// The lane model returns rs1+rs2+rs3 computed from the lane buses.
// Every expected warp result is built independently from the stimulus.
module tb_gelato_warp_alu_dispatch;

    localparam int TN = 32;
    localparam int DW = 32;
    localparam int OW = 6;
    localparam int LA = 8;
    localparam int LB = 32;
    localparam int WW = TN * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Operand buses are shared by both instances.
    logic [OW-1:0] task_op;
    logic [WW-1:0] task_rs1, task_rs2, task_rs3;

    logic          task_valid_a, task_done_a, alu_valid_a;
    logic [WW-1:0] task_rd_a;
    logic [OW-1:0] alu_op_a;
    logic [LA*DW-1:0] alu_rs1_a, alu_rs2_a, alu_rs3_a, alu_rd_a;
    logic [LA-1:0] alu_done_a;

    logic          task_valid_b, task_done_b, alu_valid_b;
    logic [WW-1:0] task_rd_b;
    logic [OW-1:0] alu_op_b;
    logic [LB*DW-1:0] alu_rs1_b, alu_rs2_b, alu_rs3_b, alu_rd_b;
    logic [LB-1:0] alu_done_b;

    gelato_warp_alu_dispatch #(
        .THREAD_NUM(TN), .LANE_NUM(LA), .DATA_WIDTH(DW), .OP_WIDTH(OW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .task_valid(task_valid_a), .task_op(task_op),
        .task_rs1(task_rs1), .task_rs2(task_rs2), .task_rs3(task_rs3),
        .task_done(task_done_a), .task_rd(task_rd_a),
        .alu_valid(alu_valid_a), .alu_op(alu_op_a),
        .alu_rs1(alu_rs1_a), .alu_rs2(alu_rs2_a), .alu_rs3(alu_rs3_a),
        .alu_done(alu_done_a), .alu_rd(alu_rd_a)
    );

    gelato_warp_alu_dispatch #(
        .THREAD_NUM(TN), .LANE_NUM(LB), .DATA_WIDTH(DW), .OP_WIDTH(OW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .task_valid(task_valid_b), .task_op(task_op),
        .task_rs1(task_rs1), .task_rs2(task_rs2), .task_rs3(task_rs3),
        .task_done(task_done_b), .task_rd(task_rd_b),
        .alu_valid(alu_valid_b), .alu_op(alu_op_b),
        .alu_rs1(alu_rs1_b), .alu_rs2(alu_rs2_b), .alu_rs3(alu_rs3_b),
        .alu_done(alu_done_b), .alu_rd(alu_rd_b)
    );

    int checks = 0;
    int errors = 0;
    logic [WW-1:0] exp_rd;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mode 0: every lane answers one cycle after issue.
    // Mode 1: in batch 0, lanes 0-3 answer at issue+1 and lanes 4-7 at issue+3.
    // Mode 2: in batch 0, lane 2 answers 0xAAAA at issue+1, then all lanes
    //         answer at issue+2 (lane 2 sends 0xBBBB).
    // Mode 3: like mode 0, but reset is asserted in the WAIT cycle of batch 2.
    task automatic run_a(input int mode, input logic [OW-1:0] op, input int exp_lat);
        int since, pulses, done_k, gap_exp;
        logic aborted;
        logic [LA-1:0] dmask;
        since = 0; pulses = 0; done_k = 0; aborted = 1'b0;
        @(negedge clk);
        task_op = op;
        task_valid_a = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            since++;
            if (alu_valid_a) begin
                if (pulses == 0) begin
                    check("first_issue", k, 1);
                end else begin
                    gap_exp = (pulses == 1 && mode == 1) ? 4 : (pulses == 1 && mode == 2) ? 3 : 2;
                    check("issue_gap", since, gap_exp);
                end
                check("alu_op", alu_op_a, op);
                pulses++;
                since = 0;
            end
            alu_done_a = '0;
            if (mode == 3 && pulses == 3 && since == 1) begin
                aborted = 1'b1;
                break;
            end
            dmask = '0;
            if (pulses > 0) begin
                if (mode == 1 && pulses == 1)
                    dmask = (since == 1) ? 8'h0F : (since == 3) ? 8'hF0 : 8'h00;
                else if (mode == 2 && pulses == 1)
                    dmask = (since == 1) ? 8'h04 : (since == 2) ? 8'hFF : 8'h00;
                else
                    dmask = (since == 1) ? 8'hFF : 8'h00;
            end
            for (int l = 0; l < LA; l++)
                alu_rd_a[l*DW +: DW] = alu_rs1_a[l*DW +: DW] + alu_rs2_a[l*DW +: DW] + alu_rs3_a[l*DW +: DW];
            if (mode == 2 && pulses == 1)
                alu_rd_a[2*DW +: DW] = (since == 1) ? 32'hAAAA : 32'hBBBB;
            alu_done_a = dmask;
            if (task_done_a) begin
                done_k = k;
                break;
            end
        end
        if (mode == 3) begin
            check("abort_reached", aborted, 1'b1);
            if (aborted) begin
                #2 rst_n = 1'b0;
                task_valid_a = 1'b0;
                #1;
                check("rst_task_done", task_done_a, 0);
                check("rst_alu_valid", alu_valid_a, 0);
                check("rst_task_rd", task_rd_a, 0);
                check("rst_alu_op", alu_op_a, 0);
                check("rst_alu_rs1", alu_rs1_a, 0);
            end
        end else begin
            check("latency", done_k - 1, exp_lat);
            check("issue_count", pulses, 4);
        end
    endtask

    task automatic run_b();
        int since, pulses, done_k;
        since = 0; pulses = 0; done_k = 0;
        @(negedge clk);
        task_valid_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            since++;
            if (alu_valid_b) begin
                pulses++;
                since = 0;
            end
            alu_done_b = '0;
            for (int l = 0; l < LB; l++)
                alu_rd_b[l*DW +: DW] = alu_rs1_b[l*DW +: DW] + alu_rs2_b[l*DW +: DW] + alu_rs3_b[l*DW +: DW];
            if (pulses > 0 && since == 1) alu_done_b = '1;
            if (task_done_b) begin
                done_k = k;
                break;
            end
        end
        check("b_latency", done_k - 1, 2);
        check("b_issue_count", pulses, 1);
    endtask

    task automatic drop_a();
        task_valid_a = 1'b0;
        @(negedge clk);
        check("idle_after_drop", task_done_a, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        task_valid_a = 1'b0; task_valid_b = 1'b0;
        task_op = '0; task_rs1 = '0; task_rs2 = '0; task_rs3 = '0;
        alu_done_a = '0; alu_rd_a = '0; alu_done_b = '0; alu_rd_b = '0;
        repeat (2) @(negedge clk);
        check("reset_task_done", task_done_a, 0);
        check("reset_alu_valid", alu_valid_a, 0);
        check("reset_task_rd", task_rd_a, 0);
        check("reset_alu_op", alu_op_a, 0);
        check("reset_b_task_done", task_done_b, 0);
        rst_n = 1'b1;

        // Basic warp: rs1[t]=t, rs2[t]=100.
        for (int t = 0; t < TN; t++) begin
            task_rs1[t*DW +: DW] = t;
            task_rs2[t*DW +: DW] = 100;
            task_rs3[t*DW +: DW] = 0;
            exp_rd[t*DW +: DW] = t + 100;
        end
        run_a(0, 6'h05, 8);
        check("rd_basic", task_rd_a, exp_rd);
        // The held request must not be re-accepted.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_done", task_done_a, 1);
            check("hold_no_issue", alu_valid_a, 0);
        end
        drop_a();

        // Staggered lanes in batch 0; rs3 takes part in the result.
        for (int t = 0; t < TN; t++) begin
            task_rs1[t*DW +: DW] = 3 * t;
            task_rs2[t*DW +: DW] = 7;
            task_rs3[t*DW +: DW] = 1000;
            exp_rd[t*DW +: DW] = 3 * t + 1007;
        end
        run_a(1, 6'h2A, 10);
        check("rd_stagger", task_rd_a, exp_rd);
        drop_a();

        // Lane 2 reports twice; only the first result is kept.
        for (int t = 0; t < TN; t++) begin
            task_rs1[t*DW +: DW] = t;
            task_rs2[t*DW +: DW] = 16;
            task_rs3[t*DW +: DW] = 0;
            exp_rd[t*DW +: DW] = t + 16;
        end
        exp_rd[2*DW +: DW] = 32'hAAAA;
        run_a(2, 6'h11, 9);
        check("rd_first_kept", task_rd_a, exp_rd);
        drop_a();

        // Reset during batch 2 WAIT, then a stray lane completion.
        run_a(3, 6'h01, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        alu_done_a = '1;
        alu_rd_a = {LA{32'h5A5A5A5A}};
        @(negedge clk);
        alu_done_a = '0;
        repeat (2) begin
            @(negedge clk);
            check("stray_task_done", task_done_a, 0);
            check("stray_alu_valid", alu_valid_a, 0);
            check("stray_task_rd", task_rd_a, 0);
        end

        // Recovery after reset: a fresh task completes normally.
        for (int t = 0; t < TN; t++) begin
            task_rs1[t*DW +: DW] = t;
            task_rs2[t*DW +: DW] = 100;
            exp_rd[t*DW +: DW] = t + 100;
        end
        run_a(0, 6'h05, 8);
        check("rd_recover", task_rd_a, exp_rd);
        drop_a();

        // Single-batch instance.
        for (int t = 0; t < TN; t++) begin
            task_rs1[t*DW +: DW] = t << 4;
            task_rs2[t*DW +: DW] = 5;
            task_rs3[t*DW +: DW] = 0;
            exp_rd[t*DW +: DW] = (t << 4) + 5;
        end
        run_b();
        check("b_rd", task_rd_b, exp_rd);
        task_valid_b = 1'b0;
        @(negedge clk);
        check("b_idle_after_drop", task_done_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
